dac_sample_feeder: RTL and testbench



---
 rtl/dac_feeder_pkg.sv | 12 +
 rtl/dac_feeder_fifo.sv | 55 +++++
 rtl/dac_sample_feeder.sv | 148 ++++++++++++++
 tb/tb_dac_sample_feeder.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_feeder_pkg.sv
// Shared types and widths for the DAC sample feeder.
package dac_feeder_pkg;
  localparam int SAMPLE_W = 12;
  localparam int MODE_W   = 2;
  localparam int ENTRY_W  = SAMPLE_W + MODE_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TICK = 2'd1,
    PRESENT   = 2'd2
  } state_e;
endpackage

// File: rtl/dac_feeder_fifo.sv
// Synchronous FIFO: combinational head read, push rejected at full,
// pop ignored when empty. DEPTH must be a power of two so pointers wrap.
module dac_feeder_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 14
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign full_o     = (level_q == (AW+1)'(DEPTH));
  assign empty_o    = (level_q == '0);
  assign level_o    = level_q;
  assign pop_data_o = mem_q[rd_ptr_q];
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;

  // Occupancy: simultaneous push and pop leaves it unchanged.
  always_comb begin
    level_d = level_q;
    if (do_push && !do_pop)      level_d = level_q + 1'b1;
    else if (do_pop && !do_push) level_d = level_q - 1'b1;
  end

  // Storage array; contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end
endmodule

// File: rtl/dac_sample_feeder.sv
// Feeds buffered {mode, sample} entries to the MCP4725 interface at a
// programmable period and waits for the echoed registers to match.
// Optional feature macro: DAC_FEEDER_RAMP_EN adds a FIFO-bypassing ramp
// generator (ramp_mode/ramp_step ports).
module dac_sample_feeder
  import dac_feeder_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int DIV_W = 16,
  parameter int TO_W  = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ENTRY_W-1:0]     wr_data,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  output logic [$clog2(DEPTH):0] level,
  input  logic                   run,
  input  logic [DIV_W-1:0]       period,
  input  logic                   clr_err,
  output logic [SAMPLE_W-1:0]    data_o,
  output logic [MODE_W-1:0]      mode_o,
  output logic                   enable_o,
  input  logic [SAMPLE_W-1:0]    data_echo,
  input  logic [MODE_W-1:0]      mode_echo,
  output logic                   busy,
  output logic                   underflow,
  output logic                   timeout_err
`ifdef DAC_FEEDER_RAMP_EN
  ,
  input  logic                   ramp_mode,
  input  logic [SAMPLE_W-1:0]    ramp_step
`endif
);
  state_e              state_q, state_d;
  logic [DIV_W-1:0]    cnt_q, cnt_d;
  logic [TO_W-1:0]     to_q, to_d;
  logic [SAMPLE_W-1:0] data_q, data_d, ramp_data;
  logic [MODE_W-1:0]   mode_q, mode_d;
  logic                uf_q, uf_d, te_q, te_d;
  logic                pop, launch, accept, uf_set, te_set, ramp_sel;
  logic [ENTRY_W-1:0]  head;
  logic                full, empty;

  dac_feeder_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (wr_valid),
    .push_data_i(wr_data),
    .pop_i      (pop),
    .pop_data_o (head),
    .full_o     (full),
    .empty_o    (empty),
    .level_o    (level)
  );

`ifdef DAC_FEEDER_RAMP_EN
  assign ramp_sel  = ramp_mode;
  assign ramp_data = data_q + ramp_step;
`else
  assign ramp_sel  = 1'b0;
  assign ramp_data = data_q;
`endif

  assign wr_ready    = !full;
  assign data_o      = data_q;
  assign mode_o      = mode_q;
  assign enable_o    = (state_q == PRESENT);
  assign busy        = (state_q == PRESENT);
  assign underflow   = uf_q;
  assign timeout_err = te_q;
  // An echo that already matches (repeat sample) accepts with no I2C traffic.
  assign accept      = (data_echo == data_q) && (mode_echo == mode_q);

  // Launch FSM: next state, pop and flag-set strobes.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    mode_d  = mode_q;
    pop     = 1'b0;
    launch  = 1'b0;
    uf_set  = 1'b0;
    te_set  = 1'b0;
    case (state_q)
      IDLE: if (run) state_d = WAIT_TICK;
      WAIT_TICK: begin
        if (!run) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          if (ramp_sel) begin
            launch = 1'b1;
            data_d = ramp_data;
            mode_d = '0;
          end else if (!empty) begin
            launch           = 1'b1;
            pop              = 1'b1;
            {mode_d, data_d} = head;
          end else begin
            uf_set = 1'b1;
          end
        end
      end
      PRESENT: begin
        if (accept) begin
          state_d = run ? WAIT_TICK : IDLE;
        end else if (&to_q) begin
          te_set  = 1'b1;
          state_d = WAIT_TICK;
        end
      end
      default: state_d = IDLE;
    endcase
    if (launch) state_d = PRESENT;
  end

  // Period counter: the load cycle also counts as a decrement so that
  // launches land exactly `period` cycles apart.
  always_comb begin
    if (launch)
      cnt_d = (period == '0) ? '0 : period - DIV_W'(1);
    else
      cnt_d = (cnt_q == '0) ? '0 : cnt_q - DIV_W'(1);
    to_d = launch ? '0 : (state_q == PRESENT) ? to_q + 1'b1 : to_q;
    uf_d = uf_set | (uf_q & ~clr_err);
    te_d = te_set | (te_q & ~clr_err);
  end

  // State, output and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      to_q    <= '0;
      data_q  <= '0;
      mode_q  <= '0;
      uf_q    <= 1'b0;
      te_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      uf_q    <= uf_d;
      te_q    <= te_d;
    end
  end
endmodule

// File: tb/tb_dac_sample_feeder.sv
// Randomized self-checking bench for dac_sample_feeder with a DAC echo model.
module tb_dac_sample_feeder;
  localparam int DEPTH = 16;
  localparam int DIV_W = 16;
  localparam int TO_W  = 6;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [13:0] wr_data = '0;
  logic wr_valid = 1'b0;
  logic wr_ready;
  logic [LW-1:0] level;
  logic run = 1'b0;
  logic [DIV_W-1:0] period = '0;
  logic clr_err = 1'b0;
  logic [11:0] data_o;
  logic [1:0] mode_o;
  logic enable_o;
  logic [11:0] data_echo = '0;
  logic [1:0] mode_echo = '0;
  logic busy, underflow, timeout_err;
`ifdef DAC_FEEDER_RAMP_EN
  logic ramp_mode = 1'b0;
  logic [11:0] ramp_step = '0;
`endif

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  dac_sample_feeder #(.DEPTH(DEPTH), .DIV_W(DIV_W), .TO_W(TO_W)) dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .level(level), .run(run), .period(period), .clr_err(clr_err),
    .data_o(data_o), .mode_o(mode_o), .enable_o(enable_o),
    .data_echo(data_echo), .mode_echo(mode_echo),
    .busy(busy), .underflow(underflow), .timeout_err(timeout_err)
`ifdef DAC_FEEDER_RAMP_EN
    , .ramp_mode(ramp_mode), .ramp_step(ramp_step)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // DAC model and launch monitor. The DAC copies the presented value into its
  // echo registers lat+1 cycles after enable_o rises (never, if no_echo).
  int lat = 1;
  bit no_echo = 1'b0;
  int dac_wait = 0;
  bit en_prev = 1'b0;
  int rise_at = 0;
  int rise_cyc[$];
  logic [13:0] rise_val[$];
  int hi_len[$];
  always @(negedge clk) begin
    if (enable_o && !en_prev) begin
      rise_cyc.push_back(cyc);
      rise_val.push_back({mode_o, data_o});
      rise_at = cyc;
    end
    if (!enable_o && en_prev) hi_len.push_back(cyc - rise_at);
    en_prev = enable_o;
    if (rst) begin
      data_echo = '0; mode_echo = '0; dac_wait = 0;
    end else if (enable_o && {mode_echo, data_echo} != {mode_o, data_o}) begin
      dac_wait++;
      if (!no_echo && dac_wait >= lat + 1) begin
        data_echo = data_o; mode_echo = mode_o; dac_wait = 0;
      end
    end else begin
      dac_wait = 0;
    end
  end

  // Stream reference: expected entries, period, latency and starting echo.
  logic [13:0] exp_q[$];
  int s_base, h_base, s_per, s_lat;
  logic [13:0] s_echo;

  task automatic push(input logic [13:0] v);
    wr_data = v; wr_valid = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic stream_begin(input int per, input int l);
    lat = l; no_echo = 1'b0; s_per = per; s_lat = l;
    s_base = rise_cyc.size(); h_base = hi_len.size();
    s_echo = {mode_echo, data_echo};
    @(negedge clk);
    period = DIV_W'(per);
    foreach (exp_q[i]) push(exp_q[i]);
    tests++;
    if (level !== LW'(exp_q.size())) begin
      fails++; $display("FAIL stream_level: got %0d want %0d", level, exp_q.size());
    end
  endtask

  // Expected: entries in order; enable high lat+1 cycles (1 if echo already
  // matches); launch spacing max(period, previous high time + 1).
  task automatic stream_end(input string nm);
    int n, k, eh, ph, eg, ag;
    logic [13:0] em;
    n = exp_q.size(); k = 0;
    while (hi_len.size() < h_base + n && k < 30000) begin @(negedge clk); k++; end
    run = 1'b0;
    tests++;
    if (hi_len.size() < h_base + n) begin
      fails++; $display("FAIL %s_done: got %0d launches want %0d", nm, hi_len.size() - h_base, n);
    end else begin
      em = s_echo; ph = 0;
      for (int i = 0; i < n; i++) begin
        eh = (exp_q[i] == em) ? 1 : s_lat + 1;
        em = exp_q[i];
        tests++;
        if (rise_val[s_base+i] !== exp_q[i]) begin
          fails++; $display("FAIL %s_data[%0d]: got %h want %h", nm, i, rise_val[s_base+i], exp_q[i]);
        end
        tests++;
        if (hi_len[h_base+i] != eh) begin
          fails++; $display("FAIL %s_enable_len[%0d]: got %0d want %0d", nm, i, hi_len[h_base+i], eh);
        end
        if (i > 0) begin
          eg = (s_per > ph + 1) ? s_per : ph + 1;
          ag = rise_cyc[s_base+i] - rise_cyc[s_base+i-1];
          tests++;
          if (ag != eg) begin
            fails++; $display("FAIL %s_gap[%0d]: got %0d want %0d", nm, i, ag, eg);
          end
        end
        ph = eh;
      end
    end
    repeat (4) @(negedge clk);
    tests++;
    if (rise_cyc.size() != s_base + n) begin
      fails++; $display("FAIL %s_count: got %0d launches want %0d", nm, rise_cyc.size() - s_base, n);
    end
    clr_err = 1'b1; @(negedge clk); clr_err = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests++;
    if ({data_o, mode_o, enable_o, busy} !== 16'h0) begin
      fails++; $display("FAIL reset_outputs: got %h/%h/%b/%b want 0", data_o, mode_o, enable_o, busy);
    end
    tests++;
    if ({wr_ready, level, underflow, timeout_err} !== {1'b1, LW'(0), 2'b00}) begin
      fails++; $display("FAIL reset_status: got rdy=%b lvl=%0d uf=%b to=%b want 1/0/0/0", wr_ready, level, underflow, timeout_err);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_period();
    exp_q = {14'h0123, 14'h0456};
    stream_begin(100, 40); run = 1'b1; stream_end("period");
  endtask

  task automatic test_back_to_back();
    exp_q = {14'h07FF, 14'h07FF};
    stream_begin(0, 3); run = 1'b1; stream_end("b2b");
  endtask

  task automatic test_fifo_full();
    logic [13:0] mark;
    repeat (120) @(negedge clk);
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(14'($urandom));
    mark = ~exp_q[DEPTH-1];
    stream_begin(0, 1);
    tests++;
    if (wr_ready !== 1'b0) begin fails++; $display("FAIL full_ready: got %b want 0", wr_ready); end
    push(mark);
    tests++;
    if (level !== LW'(DEPTH)) begin fails++; $display("FAIL full_drop: got %0d want %0d", level, DEPTH); end
    // Push held across the first pop while still full: must be dropped.
    run = 1'b1; wr_data = mark; wr_valid = 1'b1;
    @(negedge clk); @(negedge clk);
    wr_valid = 1'b0;
    tests++;
    if (level !== LW'(DEPTH - 1)) begin fails++; $display("FAIL full_pop_push: got %0d want %0d", level, DEPTH - 1); end
    stream_end("fifo");
  endtask

  task automatic test_underflow();
    repeat (120) @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    tests++;
    if (underflow !== 1'b0) begin fails++; $display("FAIL uf_early: got %b want 0", underflow); end
    @(negedge clk);
    tests++;
    if (underflow !== 1'b1) begin fails++; $display("FAIL uf_first_slot: got %b want 1", underflow); end
    clr_err = 1'b1; @(negedge clk); clr_err = 1'b0;
    tests++;
    if (underflow !== 1'b1) begin fails++; $display("FAIL uf_set_wins: got %b want 1", underflow); end
    run = 1'b0;
    repeat (2) @(negedge clk);
    clr_err = 1'b1; @(negedge clk); clr_err = 1'b0;
    @(negedge clk);
    tests++;
    if (underflow !== 1'b0) begin fails++; $display("FAIL uf_clear: got %b want 0", underflow); end
  endtask

  task automatic test_timeout();
    int hb, rb, k;
    logic [13:0] a, b;
    a = {2'b01, data_echo ^ 12'hAAA};
    b = {2'b10, data_echo ^ 12'h555};
    lat = 2; no_echo = 1'b1;
    hb = hi_len.size(); rb = rise_cyc.size();
    period = '0;
    push(a); push(b);
    run = 1'b1;
    k = 0;
    while (hi_len.size() < hb + 1 && k < 500) begin @(negedge clk); k++; end
    no_echo = 1'b0;
    tests++;
    if (timeout_err !== 1'b1) begin fails++; $display("FAIL to_flag: got %b want 1", timeout_err); end
    tests++;
    if (hi_len.size() < hb + 1) begin
      fails++; $display("FAIL to_len: no timeout within 500 cycles, want about %0d", (1 << TO_W) - 1);
    end else if (hi_len[hb] < (1 << TO_W) - 1 || hi_len[hb] > (1 << TO_W)) begin
      fails++; $display("FAIL to_len: got %0d want %0d..%0d", hi_len[hb], (1 << TO_W) - 1, 1 << TO_W);
    end
    k = 0;
    while (hi_len.size() < hb + 2 && k < 500) begin @(negedge clk); k++; end
    run = 1'b0;
    tests++;
    if (rise_val.size() < rb + 2) begin
      fails++; $display("FAIL to_next: got %0d launches want 2", rise_val.size() - rb);
    end else if (rise_val[rb+1] !== b || hi_len[hb+1] != lat + 1) begin
      fails++; $display("FAIL to_next: got %h/%0d want %h/%0d", rise_val[rb+1], hi_len[hb+1], b, lat + 1);
    end
    tests++;
    if (timeout_err !== 1'b1) begin fails++; $display("FAIL to_sticky: got %b want 1", timeout_err); end
    repeat (3) @(negedge clk);
    clr_err = 1'b1; @(negedge clk); clr_err = 1'b0;
    tests++;
    if (timeout_err !== 1'b0) begin fails++; $display("FAIL to_clear: got %b want 0", timeout_err); end
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 4; it++) begin
      n = $urandom_range(1, 8);
      exp_q.delete();
      for (int i = 0; i < n; i++) begin
        if (i > 0 && $urandom_range(0, 3) == 0) exp_q.push_back(exp_q[i-1]);
        else exp_q.push_back(14'($urandom));
      end
      stream_begin($urandom_range(0, 20), $urandom_range(0, 12));
      run = 1'b1;
      stream_end("random");
    end
  endtask

`ifdef DAC_FEEDER_RAMP_EN
  task automatic test_ramp();
    int rb, hb, k;
    logic [11:0] v;
    exp_q = {14'h0C00};
    stream_begin(0, 1); run = 1'b1; stream_end("ramp_seed");
    rb = rise_cyc.size(); hb = hi_len.size();
    ramp_mode = 1'b1; ramp_step = 12'h800; run = 1'b1;
    push(14'h3123);
    k = 0;
    while (hi_len.size() < hb + 3 && k < 500) begin @(negedge clk); k++; end
    run = 1'b0;
    v = 12'hC00;
    for (int i = 0; i < 3; i++) begin
      v = v + 12'h800;
      tests++;
      if (rise_val.size() < rb + i + 1) begin
        fails++; $display("FAIL ramp_val[%0d]: missing launch want %h", i, v);
      end else if (rise_val[rb+i] !== {2'b00, v}) begin
        fails++; $display("FAIL ramp_val[%0d]: got %h want %h", i, rise_val[rb+i], {2'b00, v});
      end
    end
    tests++;
    if (underflow !== 1'b0 || level !== LW'(1)) begin
      fails++; $display("FAIL ramp_status: got uf=%b lvl=%0d want 0/1", underflow, level);
    end
    repeat (4) @(negedge clk);
    ramp_mode = 1'b0;
    clr_err = 1'b1; @(negedge clk); clr_err = 1'b0;
  endtask
`endif

  task automatic test_reset_mid_present();
    int k;
    no_echo = 1'b1;
    push({2'b00, ~data_echo}); push(14'h0055);
    run = 1'b1;
    k = 0;
    while (!enable_o && k < 200) begin @(negedge clk); k++; end
    tests++;
    if (!enable_o) begin fails++; $display("FAIL rst_mid_launch: got enable 0 want 1"); end
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    tests++;
    if ({enable_o, busy, level, data_o} !== {2'b00, LW'(0), 12'h000}) begin
      fails++; $display("FAIL rst_mid_async: got en=%b busy=%b lvl=%0d data=%h want 0/0/0/0", enable_o, busy, level, data_o);
    end
    run = 1'b0; no_echo = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (enable_o !== 1'b0 || wr_ready !== 1'b1) begin
      fails++; $display("FAIL rst_mid_after: got en=%b rdy=%b want 0/1", enable_o, wr_ready);
    end
  endtask

  initial begin
    test_reset();
    test_period();
    test_back_to_back();
    test_fifo_full();
    test_underflow();
    test_timeout();
    test_random();
`ifdef DAC_FEEDER_RAMP_EN
    test_ramp();
`endif
    test_reset_mid_present();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
